ft601_rx_reader: RTL
====================

// Module: ft601_rx_reader
// PURPOSE
// - Host->FPGA read path of the FT601 in 245 synchronous FIFO mode. It is the companion to the FPGA->host dumper.
// - Drains the FT601 receive FIFO whenever RXF_N indicates data and presents the words as an AXI-Stream master.
// - Sits in the clk_in_ft601 domain beside the transmit block and yields the bus while the transmitter is active.
// - Contains an internal skid FIFO that absorbs in-flight words when downstream back-pressures.
// PARAMETERS
// - DEPTH        8  skid FIFO depth in 32-bit words; power of 2, >=4.
// - SKID_MARGIN  3  free-slot threshold: no read is started or continued when free slots < SKID_MARGIN.
// PORTS
// - clk_in_ft601   in   1   FT601 clock (100 MHz); the only clock.
// - rst_n_in       in   1   asynchronous, active-low reset.
// - rxf_n          in   1   FT601 receive FIFO has data (active low).
// - data_in        in   32  FT601 data bus, sampled side.
// - be_in          in   4   FT601 byte enables, driven by the FT601 during reads.
// - tx_busy_in     in   1   transmitter owns the bus; blocks new read bursts.
// - oe_n           out  1   bus output enable to the FT601 (active low).
// - rd_n           out  1   read strobe (active low).
// - rx_active      out  1   high from the TURN state through the END state; the transmitter must not assert wr_n while high.
// - m_axis_tvalid  out  1   skid FIFO head valid.
// - m_axis_tready  in   1   downstream accept.
// - m_axis_tdata   out  32  head word.
// - m_axis_tkeep   out  4   head byte enables, copied from be_in.
// - overflow_err   out  1   sticky; set if a word was captured while the FIFO was full.
// BEHAVIOUR
// - All FT601-side outputs are registered. Reset values: oe_n=1, rd_n=1, rx_active=0, m_axis_tvalid=0, overflow_err=0, FIFO empty, state IDLE.
// - Reset asserted mid-burst: oe_n and rd_n go to 1 immediately (asynchronous). FIFO contents are discarded.
// - free = DEPTH - occupancy, evaluated each cycle.
// - State IDLE:
//   - Goes to TURN when rxf_n==0 && !tx_busy_in && free>=SKID_MARGIN.
//   - Next-cycle outputs: oe_n=0, rx_active=1.
// - State TURN: one-cycle bus turnaround, rd_n stays 1. Then:
//   - If rxf_n==0 && free>=SKID_MARGIN, go to READ with rd_n=0 registered.
//   - Otherwise go to END.
// - State READ:
//   - Capture rule: a word is captured on an edge where the registered rd_n==0 && rxf_n==0. {be_in,data_in} is pushed into the FIFO.
//   - Goes to END when rxf_n==1 || free<SKID_MARGIN. rd_n=1 is registered on that transition.
//   - tx_busy_in is ignored once in READ; the burst completes.
// - State END: rd_n=1 and oe_n=0 are held for one cycle, then IDLE with oe_n=1 and rx_active=0.
//   - Minimum gap between bursts is 1 IDLE cycle.
// - Latency: rxf_n falling at edge N gives oe_n=0 at N+1, rd_n=0 at N+2, first capture at N+3, m_axis_tvalid at N+4.
// - AXI handshake:
//   - A pop occurs on m_axis_tvalid && m_axis_tready.
//   - tdata/tkeep are stable while tvalid && !tready.
//   - A push and a pop in the same cycle leave occupancy unchanged and are legal when full.
// - Boundaries:
//   - Full with no pop: the capture is dropped and overflow_err is set (unreachable with SKID_MARGIN>=3).
//   - Pointers wrap modulo DEPTH.
//   - Empty: tvalid=0.
//   - rxf_n rising in the same cycle as a capture edge: that word is not captured.
// CONFIGURATION
// - Macro FT601_RX_STATS_EN.
// - Defined: the block adds outputs rx_word_count[31:0] and rx_partial_count[15:0].
//   - rx_word_count increments on every capture and wraps at 2^32.
//   - rx_partial_count increments on every capture with be_in!=4'b1111 and saturates at 16'hFFFF.
//   - Both reset to 0.
// - Not defined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Reset with rxf_n=0: oe_n=rd_n=1 and tvalid=0 while rst_n_in=0. The first oe_n=0 occurs 1 edge after release.
// - Burst: rxf_n low for 16 data cycles, data 0x0..0xF, tready=1 -> 16 words in order, tkeep=4'hF, rd_n high within 1 cycle of rxf_n rising, overflow_err=0.
// - Back-pressure: 32-word host burst, tready=0 -> rd_n deasserts when occupancy reaches DEPTH-SKID_MARGIN+1.
//   - Releasing tready yields all 32 words, no loss, no duplicates.
// - Partial word: last word with be_in=4'b0011 -> m_axis_tkeep=4'b0011 for that word.
//   - With FT601_RX_STATS_EN: rx_partial_count=1.
// - Arbitration: tx_busy_in=1 with rxf_n=0 -> state stays IDLE and oe_n=1.
//   - tx_busy_in falling -> oe_n=0 on the next edge.
// - Async reset mid-READ: rst_n_in pulsed low -> rd_n/oe_n=1 with no clock edge, FIFO empty, the next burst restarts cleanly.

Source files
------------

// File: rtl/ft601_rx_reader.sv
// FT601 245-sync-FIFO receive path: drains RXF_N into a skid FIFO presented as an AXI-Stream master.
// Optional per-word statistics outputs appear when FT601_RX_STATS_EN is defined.
//
// state | meaning
// IDLE  | bus released (oe_n=1); waits for data, a free bus and enough FIFO room
// TURN  | oe_n asserted, one-cycle bus turnaround before strobing rd_n
// READ  | rd_n asserted; a word is captured on every edge with rxf_n low
// END   | rd_n released, oe_n held one more cycle before handing the bus back
module ft601_rx_reader #(
   parameter int DEPTH       = 8,
   parameter int SKID_MARGIN = 3
) (
   input  logic        clk_in_ft601,
   input  logic        rst_n_in,
   input  logic        rxf_n,
   input  logic [31:0] data_in,
   input  logic [3:0]  be_in,
   input  logic        tx_busy_in,
   output logic        oe_n,
   output logic        rd_n,
   output logic        rx_active,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic [3:0]  m_axis_tkeep,
`ifdef FT601_RX_STATS_EN
   output logic [31:0] rx_word_count,
   output logic [15:0] rx_partial_count,
`endif
   output logic        overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] MARGIN   = (AW+1)'(SKID_MARGIN);

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_READ, S_END} state_t;

   state_t state, state_nx;
   logic   oe_nx, rd_nx, active_nx;

   logic [35:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, free;
   logic          room, full, push, pop, capture;
   logic          cap_vld;
   logic [35:0]   cap_word;

   assign free    = FULL_CNT - count;
   assign room    = (free >= MARGIN);
   assign full    = (count == FULL_CNT);
   assign capture = !rd_n && !rxf_n;
   assign pop     = m_axis_tvalid && m_axis_tready;
   // A push into a full FIFO is still fine when the head leaves on the same edge.
   assign push    = cap_vld && (!full || pop);

   assign m_axis_tvalid = (count != '0);
   assign {m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

   always_ff @(posedge clk_in_ft601 or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= S_IDLE;
         oe_n      <= 1'b1;
         rd_n      <= 1'b1;
         rx_active <= 1'b0;
      end else begin
         state     <= state_nx;
         oe_n      <= oe_nx;
         rd_n      <= rd_nx;
         rx_active <= active_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      oe_nx     = oe_n;
      rd_nx     = rd_n;
      active_nx = rx_active;
      case (state)
         S_IDLE: begin
            if (!rxf_n && !tx_busy_in && room) begin
               state_nx  = S_TURN;
               oe_nx     = 1'b0;
               active_nx = 1'b1;
            end
         end
         S_TURN: begin
            if (!rxf_n && room) begin
               state_nx = S_READ;
               rd_nx    = 1'b0;
            end else begin
               state_nx = S_END;
            end
         end
         S_READ: begin
            if (rxf_n || !room) begin
               state_nx = S_END;
               rd_nx    = 1'b1;
            end
         end
         S_END: begin
            state_nx  = S_IDLE;
            oe_nx     = 1'b1;
            active_nx = 1'b0;
         end
         default: begin
            state_nx  = S_IDLE;
            oe_nx     = 1'b1;
            rd_nx     = 1'b1;
            active_nx = 1'b0;
         end
      endcase
   end

   // Input capture stage: words land here first, then enter the FIFO on the next edge.
   always_ff @(posedge clk_in_ft601 or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cap_vld  <= 1'b0;
         cap_word <= '0;
      end else begin
         cap_vld <= capture;
         if (capture) cap_word <= {be_in, data_in};
      end
   end

   always_ff @(posedge clk_in_ft601 or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cap_vld && full && !pop) overflow_err <= 1'b1;
      end
   end

   always_ff @(posedge clk_in_ft601) begin
      if (push) mem[wr_ptr] <= cap_word;
   end

`ifdef FT601_RX_STATS_EN
   always_ff @(posedge clk_in_ft601 or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rx_word_count    <= '0;
         rx_partial_count <= '0;
      end else if (capture) begin
         rx_word_count <= rx_word_count + 32'd1;
         if (be_in != 4'hF && rx_partial_count != 16'hFFFF)
            rx_partial_count <= rx_partial_count + 16'd1;
      end
   end
`endif

endmodule
